// File: rtl/laser_ranger_avg.sv
// Laser rangefinder controller: fires 2^SHOTS_LOG2 pulses, times each return
// in clk cycles and reports the truncated average on data with a valid pulse.
module laser_ranger_avg #(
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       SHOTS_LOG2 = 2,
    parameter int unsigned       PULSE_LEN  = 2,
    parameter logic [DATA_W-1:0] TIMEOUT    = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              laser_reflect,
    output logic              act_laser,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned ACC_W   = DATA_W + SHOTS_LOG2;
    localparam int unsigned SHOT_W  = SHOTS_LOG2 + 1;
    localparam int unsigned PULSE_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [SHOT_W-1:0]  SHOTS      = SHOT_W'(2 ** SHOTS_LOG2);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [DATA_W-1:0]  wait_cnt;
    logic [SHOT_W-1:0]  shot_cnt;
    logic [ACC_W-1:0]   acc;

    logic [SHOT_W-1:0]  shot_next;
    logic [ACC_W-1:0]   acc_next;

    // Accumulator has SHOTS_LOG2 guard bits, so summing 2^SHOTS_LOG2 samples cannot wrap.
    assign shot_next = shot_cnt + SHOT_W'(1);
    assign acc_next  = acc + ACC_W'(wait_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pulse_cnt   <= '0;
            wait_cnt    <= '0;
            shot_cnt    <= '0;
            acc         <= '0;
            act_laser   <= 1'b0;
            data        <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn) begin
                        state       <= FIRE;
                        acc         <= '0;
                        shot_cnt    <= '0;
                        pulse_cnt   <= '0;
                        timeout_err <= 1'b0;
                        act_laser   <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                FIRE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= WAIT;
                        act_laser <= 1'b0;
                        wait_cnt  <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PULSE_W'(1);
                    end
                end
                WAIT: begin
                    // A return coinciding with the timeout count still counts as a sample.
                    if (laser_reflect) begin
                        acc      <= acc_next;
                        shot_cnt <= shot_next;
                        if (shot_next == SHOTS) begin
                            state <= DONE;
                            data  <= DATA_W'(acc_next >> SHOTS_LOG2);
                            valid <= 1'b1;
                        end else begin
                            state     <= FIRE;
                            pulse_cnt <= '0;
                            act_laser <= 1'b1;
                        end
                    end else if (wait_cnt == TIMEOUT) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + DATA_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_ranger_avg.sv
// Bench for laser_ranger_avg: a 4-shot 8-bit unit (TIMEOUT=20) and a 1-shot 16-bit
// unit, each checked every cycle against a per-cycle timeline built from shot delays.
module tb_laser_ranger_avg;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn;
    logic        refl;
    bit          cur;

    logic        btn_a, btn_b;
    logic        act_a, valid_a, busy_a, terr_a;
    logic [7:0]  data_a;
    logic        act_b, valid_b, busy_b, terr_b;
    logic [15:0] data_b;

    int n_pass = 0;
    int n_chk  = 0;
    int exp_data [2];
    bit exp_terr [2];
    int dly [4];

    always #5 clk = ~clk;

    assign btn_a = btn & ~cur;
    assign btn_b = btn & cur;

    laser_ranger_avg #(
        .DATA_W(8), .SHOTS_LOG2(2), .PULSE_LEN(P), .TIMEOUT(8'd20)
    ) dut_a (
        .clk(clk), .rst(rst), .btn(btn_a), .laser_reflect(refl),
        .act_laser(act_a), .data(data_a), .valid(valid_a), .busy(busy_a),
        .timeout_err(terr_a)
    );

    laser_ranger_avg #(
        .DATA_W(16), .SHOTS_LOG2(0), .PULSE_LEN(P)
    ) dut_b (
        .clk(clk), .rst(rst), .btn(btn_b), .laser_reflect(refl),
        .act_laser(act_b), .data(data_b), .valid(valid_b), .busy(busy_b),
        .timeout_err(terr_b)
    );

    function automatic bit rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s unit=%0d: observed %0d expected %0d", tag, cur, obs, exp);
    endtask

    task automatic chk_outputs(input bit e_act, input bit e_busy, input bit e_valid);
        chk("act_laser",   32'(cur ? act_b : act_a), 32'(e_act));
        chk("busy",        32'(cur ? busy_b : busy_a), 32'(e_busy));
        chk("valid",       32'(cur ? valid_b : valid_a), 32'(e_valid));
        chk("data",        cur ? 32'(data_b) : 32'(data_a), 32'(exp_data[cur]));
        chk("timeout_err", 32'(cur ? terr_b : terr_a), 32'(exp_terr[cur]));
    endtask

    // Apply inputs for one rising edge, then check outputs at the following falling edge.
    task automatic step(input bit b, input bit r, input bit e_act, input bit e_busy,
                        input bit e_valid);
        btn  = b;
        refl = r;
        @(posedge clk);
        @(negedge clk);
        chk_outputs(e_act, e_busy, e_valid);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rb(), 1'b0, 1'b0, 1'b0);
    endtask

    // One measurement from IDLE using dly[] (negative delay = no return).
    // btn and reflect are randomised wherever the design must ignore them.
    task automatic measure(input bit hold);
        int  ns   = cur ? 1 : 4;
        int  tmo  = cur ? 65535 : 20;
        int  sl   = cur ? 0 : 2;
        int  sum  = 0;
        bit  tout = 1'b0;
        exp_terr[cur] = 1'b0;
        step(1'b1, rb(), 1'b1, 1'b1, 1'b0);
        for (int s = 0; s < ns && !tout; s++) begin
            for (int f = 1; f < P; f++) step(rb(), rb(), 1'b1, 1'b1, 1'b0);
            step(rb(), rb(), 1'b0, 1'b1, 1'b0);
            if (dly[s] < 0) begin
                for (int k = 0; k < tmo; k++) step(rb(), 1'b0, 1'b0, 1'b1, 1'b0);
                exp_terr[cur] = 1'b1;
                step(rb(), 1'b0, 1'b0, 1'b0, 1'b0);
                tout = 1'b1;
            end else begin
                for (int k = 0; k < dly[s]; k++) step(rb(), 1'b0, 1'b0, 1'b1, 1'b0);
                sum += dly[s];
                if (s == ns - 1) begin
                    exp_data[cur] = sum >> sl;
                    step(rb(), 1'b1, 1'b0, 1'b1, 1'b1);
                end else begin
                    step(rb(), 1'b1, 1'b1, 1'b1, 1'b0);
                end
            end
        end
        if (!tout) step(hold ? 1'b1 : rb(), rb(), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        refl = 1'b0;
        cur = 1'b0;
        exp_data = '{0, 0};
        exp_terr = '{1'b0, 1'b0};
        #3;
        chk_outputs(1'b0, 1'b0, 1'b0);
        cur = 1'b1;
        chk_outputs(1'b0, 1'b0, 1'b0);
        cur = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Averaging: 10+11+12+14 = 47 -> 11
        dly = '{10, 11, 12, 14};
        measure(1'b0);
        idle(2);
        // Random delays, including the timeout boundary value
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 4; s++) dly[s] = int'($urandom_range(20, 0));
            measure(1'b0);
            idle(int'($urandom_range(2, 0)));
        end
        // Return exactly at TIMEOUT and at the first WAIT cycle
        dly = '{20, 0, 20, 3};
        measure(1'b0);
        idle(1);
        // Timeout on shot 2: error set, data held, no valid
        dly = '{4, -1, 0, 0};
        measure(1'b0);
        idle(3);
        // Next start clears the error
        dly = '{1, 2, 3, 4};
        measure(1'b0);
        idle(1);

        // Reset in the 3rd WAIT cycle of shot 2
        dly = '{3, 0, 0, 0};
        step(1'b1, rb(), 1'b1, 1'b1, 1'b0);
        step(rb(), rb(), 1'b1, 1'b1, 1'b0);
        step(rb(), rb(), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(rb(), 1'b0, 1'b0, 1'b1, 1'b0);
        step(rb(), 1'b1, 1'b1, 1'b1, 1'b0);
        step(rb(), rb(), 1'b1, 1'b1, 1'b0);
        step(rb(), rb(), 1'b0, 1'b1, 1'b0);
        step(rb(), 1'b0, 1'b0, 1'b1, 1'b0);
        step(rb(), 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        exp_data[0] = 0;
        exp_terr[0] = 1'b0;
        chk_outputs(1'b0, 1'b0, 1'b0);
        btn = 1'b1;
        refl = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_outputs(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);
        dly = '{7, 8, 9, 6};
        measure(1'b0);

        // btn held: back-to-back measurements with a single IDLE cycle
        dly = '{2, 5, 1, 9};
        measure(1'b1);
        dly = '{6, 6, 6, 7};
        measure(1'b1);
        measure(1'b0);
        idle(2);

        // Single-shot unit: return on the 6th WAIT cycle -> 5
        cur = 1'b1;
        dly = '{5, 0, 0, 0};
        measure(1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            dly[0] = int'($urandom_range(60, 0));
            measure(i[0]);
            if (!i[0]) idle(1);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
